// File: rtl/dino_jump_ctrl.sv
// Per-frame dino sprite motion: ground/rise/fall FSM driven by a jump button.
// Optional: define VARIABLE_JUMP_EN for short hops on early button release.
module dino_jump_ctrl #(
  parameter int X_POS      = 100,
  parameter int GROUND_Y   = 400,
  parameter int JUMP_V     = 16,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL_V = 16,
  parameter int CUT_V      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       freeze,
  output logic [9:0] x_desired,
  output logic [9:0] y_desired,
  output logic [1:0] state,
  output logic       airborne,
  output logic       landed,
  output logic [7:0] jump_count
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } st_e;

  localparam logic [9:0]        GY_C   = 10'(GROUND_Y);
  localparam logic [9:0]        TKOF_Y = 10'(GROUND_Y - JUMP_V);
  localparam logic signed [7:0] V0_C   = 8'(JUMP_V - GRAVITY);
  localparam logic signed [8:0] GRAV_C = 9'(GRAVITY);
  localparam logic signed [8:0] VMIN_C = 9'(-MAX_FALL_V);

  st_e               st_q, st_d;
  logic [9:0]        y_q, y_d;
  logic signed [7:0] vel_q, vel_d;
  logic              pend_q, pend_d;
  logic              landed_q, landed_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              btn_q;

  logic               edge_w, tick_w, req_w;
  logic signed [7:0]  vuse;
  logic signed [10:0] ny;
  logic signed [8:0]  nv;

  assign edge_w = jump_btn & ~btn_q;
  assign tick_w = frame_tick & ~freeze;
  assign req_w  = pend_q | edge_w;

  always_comb begin
    st_d     = st_q;
    y_d      = y_q;
    vel_d    = vel_q;
    cnt_d    = cnt_q;
    landed_d = 1'b0;
    pend_d   = ~freeze & ~frame_tick & req_w;
    vuse     = vel_q;
`ifdef VARIABLE_JUMP_EN
    // Early release clamps the rise speed for a short hop.
    if (st_q == RISE && !jump_btn && vel_q > 8'(CUT_V))
      vuse = 8'(CUT_V);
`endif
    ny = $signed({1'b0, y_q}) - $signed({{3{vuse[7]}}, vuse});
    nv = $signed({vuse[7], vuse}) - GRAV_C;
    if (nv < VMIN_C)
      nv = VMIN_C;
    if (tick_w) begin
      unique case (st_q)
        GROUND: begin
          if (req_w) begin
            y_d   = TKOF_Y;
            vel_d = V0_C;
            st_d  = (V0_C > 8'sd0) ? RISE : FALL;
            if (cnt_q != 8'hFF)
              cnt_d = cnt_q + 8'd1;
          end
        end
        RISE, FALL: begin
          if (ny[10]) begin
            y_d   = '0;
            vel_d = '0;
            st_d  = FALL;
          end else if (vuse <= 8'sd0 &&
                       ny >= $signed({1'b0, GY_C})) begin
            y_d      = GY_C;
            vel_d    = '0;
            st_d     = GROUND;
            landed_d = 1'b1;
          end else begin
            y_d   = ny[9:0];
            vel_d = nv[7:0];
            st_d  = (nv > 9'sd0) ? RISE : FALL;
          end
        end
        default: begin
          st_d = GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= GROUND;
      y_q      <= GY_C;
      vel_q    <= '0;
      pend_q   <= 1'b0;
      landed_q <= 1'b0;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      y_q      <= y_d;
      vel_q    <= vel_d;
      pend_q   <= pend_d;
      landed_q <= landed_d;
      cnt_q    <= cnt_d;
      btn_q    <= jump_btn;
    end
  end

  assign x_desired  = 10'(X_POS);
  assign y_desired  = y_q;
  assign state      = st_q;
  assign airborne   = (st_q != GROUND);
  assign landed     = landed_q;
  assign jump_count = cnt_q;

endmodule
